// File: rtl/oc8051_divide_pkg.sv
// Shared constants for the DIV AB divider: operand width, bits retired per stage,
// stage count and the cycle-counter encodings.
package oc8051_divide_pkg;
    localparam int DW     = 8;
    localparam int BPC    = 2;
    localparam int STAGES = DW / BPC;

    localparam logic [1:0] CYC_FIRST = 2'd0;
    localparam logic [1:0] CYC_LAST  = 2'(STAGES - 1);
endpackage

// File: rtl/oc8051_div_step.sv
// One combinational restoring-division step: shift one dividend bit into the partial
// remainder, subtract the divisor if it fits, and emit the quotient bit.
module oc8051_div_step (
    input  logic [7:0] r,
    input  logic       dbit,
    input  logic [7:0] divisor,
    output logic [7:0] r_next,
    output logic       qbit
);
    logic [8:0] t;

    assign t    = {r, dbit};
    assign qbit = (t >= {1'b0, divisor});
    // The difference always fits 8 bits when the subtraction is taken.
    assign r_next = qbit ? 8'(t - {1'b0, divisor}) : t[7:0];
endmodule

// File: rtl/oc8051_divide.sv
// Sequential unsigned 8/8 divider for DIV AB: two restoring steps per enabled cycle,
// MSB first, quotient/remainder available combinationally in the fourth stage.
module oc8051_divide
    import oc8051_divide_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [DW-1:0] src1,
    input  logic [DW-1:0] src2,
    output logic [DW-1:0] des1,
    output logic [DW-1:0] des2,
    output logic          desOv,
    output logic          done
);
    logic [1:0]      cycle;
    logic [DW-1:0]   rem_q;
    logic [DW-3:0]   quo_q;

    logic [BPC-1:0]  dpair;
    logic [BPC-1:0]  qb;
    logic [DW-1:0]   r_ch [BPC+1];

    // Dividend bit pair consumed by the current stage, MSB pair first.
    always_comb begin
        dpair = src1[7:6];
        case (cycle)
            2'd0: dpair = src1[7:6];
            2'd1: dpair = src1[5:4];
            2'd2: dpair = src1[3:2];
            2'd3: dpair = src1[1:0];
            default: dpair = src1[7:6];
        endcase
    end

    // Stage 0 starts from zero so stale registers from an earlier division never leak in.
    assign r_ch[0] = (cycle == CYC_FIRST) ? '0 : rem_q;

    for (genvar i = 0; i < BPC; i++) begin : g_step
        oc8051_div_step u_step (
            .r       (r_ch[i]),
            .dbit    (dpair[BPC-1-i]),
            .divisor (src2),
            .r_next  (r_ch[i+1]),
            .qbit    (qb[BPC-1-i])
        );
    end

    assign des1  = (cycle == CYC_FIRST) ? {{(DW-BPC){1'b0}}, qb} : {quo_q, qb};
    assign des2  = r_ch[BPC];
    assign desOv = (src2 == '0);
    assign done  = enable & (cycle == CYC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle <= CYC_FIRST;
            rem_q <= '0;
            quo_q <= '0;
        end else if (enable) begin
            cycle <= cycle + 2'd1;
            rem_q <= des2;
            quo_q <= des1[DW-3:0];
        end
    end
endmodule

// File: tb/tb_oc8051_divide.sv
// Scoreboard bench for oc8051_divide: the driver queues the arithmetic result of every
// division it launches; a monitor pops and compares whenever done is presented.
module tb_oc8051_divide;
    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] src1, src2;
    logic [7:0] des1, des2;
    logic       desOv, done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       ov;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    exp_t sb[$];

    oc8051_divide dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .src1   (src1),
        .src2   (src2),
        .des1   (des1),
        .des2   (des2),
        .desOv  (desOv),
        .done   (done)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.a  = a;
        e.b  = b;
        e.ov = (b == 8'h00);
        if (b == 8'h00) begin
            e.q = 8'hFF;
            e.r = a;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, req);
        end
    endtask

    // Monitor: every done must match the oldest queued division.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: des1=%02h des2=%02h with empty scoreboard", des1, des2);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (des1 !== e.q || des2 !== e.r || desOv !== e.ov) begin
                    errors++;
                    $display("FAIL div %02h/%02h: got q=%02h r=%02h ov=%b expected q=%02h r=%02h ov=%b",
                             e.a, e.b, des1, des2, desOv, e.q, e.r, e.ov);
                end
            end
        end
    end

    task automatic do_reset();
        rst    = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Launch one division; pause_stage/pause_len insert enable-low clocks before a stage.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input int pause_stage, input int pause_len);
        sb.push_back(model(a, b));
        src1 = a;
        src2 = b;
        for (int k = 0; k < 4; k++) begin
            if (k == pause_stage) begin
                enable = 1'b0;
                repeat (pause_len) begin
                    if (b == 8'h00) begin
                        checks++;
                        if (desOv !== 1'b1) begin
                            errors++;
                            $display("FAIL desOv_pause: got %b expected 1", desOv);
                        end
                    end
                    @(posedge clk);
                    #1;
                end
            end
            enable = 1'b1;
            if (b == 8'h00) begin
                checks++;
                if (desOv !== 1'b1) begin
                    errors++;
                    $display("FAIL desOv_stage%0d: got %b expected 1", k, desOv);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] a, b;
        exp_t e0;
        rst    = 1'b0;
        enable = 1'b0;
        src1   = 8'h00;
        src2   = 8'h01;
        #1;
        do_reset();

        check8("reset_cycle", 8'(dut.cycle), 8'h00);
        check8("reset_rem", dut.rem_q, 8'h00);
        check8("reset_quo", 8'(dut.quo_q), 8'h00);
        check8("reset_done", 8'(done), 8'h00);

        // First stage of 8'hFF/8'h01 looks only at the top dividend pair.
        src1 = 8'hFF; src2 = 8'h01; enable = 1'b1;
        #1;
        check8("stage0_des1", des1, 8'h03);
        check8("stage0_des2", des2, 8'h00);
        enable = 1'b0;
        #1;

        // Directed cases (the scoreboard model supplies expected values).
        do_op(8'hC8, 8'h07, 9, 0);
        do_op(8'hFF, 8'h01, 9, 0);
        do_op(8'h05, 8'h0A, 9, 0);
        do_op(8'h80, 8'h80, 9, 0);
        do_op(8'h37, 8'h00, 9, 0);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Pause after stage 1: state must hold and the result must be unchanged.
        do_op(8'hC8, 8'h07, 2, 3);

        // Back-to-back with enable held high across the boundary.
        do_op(8'hC8, 8'h07, 9, 0);
        do_op(8'h09, 8'h03, 9, 0);
        enable = 1'b0;
        @(posedge clk);
        #1;

        // Abandon 200/7 at stage 2 with a reset, then run a fresh 100/9.
        src1 = 8'hC8; src2 = 8'h07; enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check8("midrst_cycle", 8'(dut.cycle), 8'h00);
        check8("midrst_rem", dut.rem_q, 8'h00);
        check8("midrst_quo", 8'(dut.quo_q), 8'h00);
        do_op(8'h64, 8'h09, 9, 0);

        // Random sweep with occasional pauses and back-to-back launches.
        for (int n = 0; n < 3000; n++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                do_op(a, b, $urandom_range(0, 3), $urandom_range(1, 3));
            else
                do_op(a, b, 9, 0);
            if ($urandom_range(0, 4) == 0) begin
                enable = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        e0 = model(8'h00, 8'h01);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never presented (q=%02h expected)", sb.size(), e0.q);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
